// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave terminating the bus in a bank of RW control registers and RO status words.
// Write AW/W are buffered independently; reads complete in one registered cycle.
module axi4_lite_reg_bank #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_RW_REGS = 8,
    parameter int unsigned NUM_RO_REGS = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [ADDR_WIDTH-1:0]                                  awaddr,
    input  logic [2:0]                                             awprot,
    input  logic                                                   awvalid,
    output logic                                                   awready,
    input  logic [DATA_WIDTH-1:0]                                  wdata,
    input  logic [DATA_WIDTH/8-1:0]                                wstrb,
    input  logic                                                   wvalid,
    output logic                                                   wready,
    output logic [1:0]                                             bresp,
    output logic                                                   bvalid,
    input  logic                                                   bready,
    input  logic [ADDR_WIDTH-1:0]                                  araddr,
    input  logic [2:0]                                             arprot,
    input  logic                                                   arvalid,
    output logic                                                   arready,
    output logic [DATA_WIDTH-1:0]                                  rdata,
    output logic [1:0]                                             rresp,
    output logic                                                   rvalid,
    input  logic                                                   rready,
    output logic [NUM_RW_REGS*DATA_WIDTH-1:0]                      ctrl_regs,
    output logic [NUM_RW_REGS-1:0]                                 ctrl_wr_pulse,
    input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*DATA_WIDTH-1:0] status_in
);

    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W   = ADDR_WIDTH - IDX_LSB;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    generate
        if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
            $error("axi4_lite_reg_bank: DATA_WIDTH must be 32 or 64");
        end
        if (NUM_RW_REGS < 1) begin : g_bad_num_rw
            $error("axi4_lite_reg_bank: NUM_RW_REGS must be at least 1");
        end
    endgenerate

    logic                    r_live;
    logic                    r_aw_held;
    logic [IDX_W-1:0]        r_aw_idx;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_RW_REGS];
    logic [NUM_RW_REGS-1:0]  r_wr_pulse;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_commit;
    logic [NUM_RW_REGS-1:0]  w_wr_sel;
    logic                    w_wr_hit;
    logic [IDX_W-1:0]        w_ar_idx;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [1:0]              w_rd_resp;
    logic                    w_unused_ok;

    // Ready flags are pure functions of flops; r_live keeps them low through reset.
    assign awready  = r_live & ~r_aw_held & ~r_bvalid;
    assign wready   = r_live & ~r_w_held  & ~r_bvalid;
    assign arready  = r_live & ~r_rvalid;

    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid  & wready;
    assign w_ar_hs  = arvalid & arready;
    assign w_commit = r_aw_held & r_w_held;
    assign w_ar_idx = araddr[ADDR_WIDTH-1:IDX_LSB];

    assign bvalid        = r_bvalid;
    assign bresp         = r_bresp;
    assign rvalid        = r_rvalid;
    assign rdata         = r_rdata;
    assign rresp         = r_rresp;
    assign ctrl_wr_pulse = r_wr_pulse;

    assign w_unused_ok = &{1'b0, awprot, arprot, awaddr[IDX_LSB-1:0], araddr[IDX_LSB-1:0]};

    generate
        for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_ctrl_out
            assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
        end
    endgenerate

    // One-hot RW select for the held write address; no hit means RO or out of range.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (r_aw_idx == IDX_W'(i)) begin
                w_wr_sel[i] = 1'b1;
            end
        end
    end

    assign w_wr_hit = |w_wr_sel;

    // Read data mux: RW bank, then status words, otherwise SLVERR with zero data.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_rd_data = r_regs[i];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int k = 0; k < NUM_RO_REGS; k++) begin
            if (w_ar_idx == IDX_W'(NUM_RW_REGS + k)) begin
                w_rd_data = status_in[k*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    // Write channel holding registers and B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live     <= 1'b0;
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_live     <= 1'b1;
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= awaddr[ADDR_WIDTH-1:IDX_LSB];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_commit) begin
                r_aw_held  <= 1'b0;
                r_w_held   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
                r_wr_pulse <= w_wr_sel;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // RW register bank with per-byte strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                for (int j = 0; j < STRB_W; j++) begin
                    if (w_wr_sel[i] && r_wstrb[j]) begin
                        r_regs[i][j*8 +: 8] <= r_wdata[j*8 +: 8];
                    end
                end
            end
        end
    end

    // Read channel: data is captured at the AR handshake and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule
